// File: rtl/pbs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pbs_pkg
// Description : Shared op codes and helper functions for the pipelined
//               barrel shifter.
// Revision    : 1.0 - initial release
// ============================================================================
package pbs_pkg;

  // Widest operand the helpers support
  localparam int MAX_W = 64;

  localparam logic [2:0] OP_SRL = 3'b000;
  localparam logic [2:0] OP_SRA = 3'b001;
  localparam logic [2:0] OP_SR1 = 3'b010;
  localparam logic [2:0] OP_ROR = 3'b011;
  localparam logic [2:0] OP_SLL = 3'b100;
  localparam logic [2:0] OP_SL1 = 3'b101;
  localparam logic [2:0] OP_ROL = 3'b110;
  localparam logic [2:0] OP_RSV = 3'b111;

  // Reverse the low w bits of x; bits at and above w come back as zero
  function automatic logic [MAX_W-1:0] bitrev(input logic [MAX_W-1:0] x, input int w);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int j = 0; j < MAX_W; j++) begin
      if (j < w) r[j] = x[w-1-j];
    end
    return r;
  endfunction

  // Bit shifted in from the top of the (possibly reversed) operand
  function automatic logic fill_bit(input logic [2:0] op, input logic msb);
    logic f;
    case (op)
      OP_SRA:         f = msb;
      OP_SR1, OP_SL1: f = 1'b1;
      default:        f = 1'b0;
    endcase
    return f;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pbs_stage.sv
`default_nettype none
// ============================================================================
// Module      : pbs_stage
// Description : One right-shift mux row (distance 2^STAGE) plus its pipeline
//               register. Rotate wraps the low bits, otherwise the carried
//               fill bit is shifted in.
// Revision    : 1.0 - initial release
// ============================================================================
module pbs_stage
  import pbs_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = 5,
  parameter int STAGE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             advance,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic             in_fill,
  input  logic             in_rot,
  input  logic             in_left,
  input  logic             in_err,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [SHW-1:0]   out_shamt,
  output logic             out_fill,
  output logic             out_rot,
  output logic             out_left,
  output logic             out_err
);

  localparam int DIST = 1 << STAGE;

  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] data_q;
  logic [SHW-1:0]   shamt_q;
  logic             valid_q, fill_q, rot_q, left_q, err_q;

  // Mux row: shift right by DIST when this stage's shift-amount bit is set
  always_comb begin
    data_d = in_data;
    if (in_shamt[STAGE]) begin
      if (in_rot) data_d = {in_data[DIST-1:0], in_data[WIDTH-1:DIST]};
      else        data_d = {{DIST{in_fill}}, in_data[WIDTH-1:DIST]};
    end
  end

  // Stage register; the whole pipeline moves together on advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      shamt_q <= '0;
      fill_q  <= 1'b0;
      rot_q   <= 1'b0;
      left_q  <= 1'b0;
      err_q   <= 1'b0;
    end else if (advance) begin
      valid_q <= in_valid;
      data_q  <= data_d;
      shamt_q <= in_shamt;
      fill_q  <= in_fill;
      rot_q   <= in_rot;
      left_q  <= in_left;
      err_q   <= in_err;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_shamt = shamt_q;
  assign out_fill  = fill_q;
  assign out_rot   = rot_q;
  assign out_left  = left_q;
  assign out_err   = err_q;

endmodule
`default_nettype wire

// File: rtl/pipelined_barrel_shifter.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_barrel_shifter
// Description : Pipelined barrel shifter, one registered stage per shift bit.
//               Left ops run through the right-shift pipe on a bit-reversed
//               operand. Valid/ready handshake with global stall.
// Revision    : 1.0 - initial release
// ============================================================================
module pipelined_barrel_shifter
  import pbs_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err
);

  // Index 0 is the entry (combinational); index k is the output of the k-th register
  logic             p_valid [0:SHW];
  logic [WIDTH-1:0] p_data  [0:SHW];
  logic [SHW-1:0]   p_shamt [0:SHW];
  logic             p_fill  [0:SHW];
  logic             p_rot   [0:SHW];
  logic             p_left  [0:SHW];
  logic             p_err   [0:SHW];

  logic             w_advance;
  logic [WIDTH-1:0] w_entry_data;
  logic [SHW-1:0]   w_entry_shamt;
  logic             w_entry_fill, w_entry_rot, w_entry_left, w_entry_err;
  logic             w_tail_unused;

  assign w_advance = !p_valid[SHW] | out_ready;
  assign in_ready  = w_advance;

  // Entry: classify op, pre-reverse left ops, pick fill bit, neutralise reserved op
  always_comb begin
    w_entry_err   = (in_op == OP_RSV);
    w_entry_left  = (in_op == OP_SLL) || (in_op == OP_SL1) || (in_op == OP_ROL);
    w_entry_rot   = (in_op == OP_ROR) || (in_op == OP_ROL);
    w_entry_fill  = fill_bit(in_op, in_data[WIDTH-1]);
    w_entry_shamt = w_entry_err ? '0 : in_shamt;
    w_entry_data  = in_data;
    if (w_entry_left) w_entry_data = WIDTH'(bitrev(MAX_W'(in_data), WIDTH));
  end

  assign p_valid[0] = in_valid;
  assign p_data[0]  = w_entry_data;
  assign p_shamt[0] = w_entry_shamt;
  assign p_fill[0]  = w_entry_fill;
  assign p_rot[0]   = w_entry_rot;
  assign p_left[0]  = w_entry_left;
  assign p_err[0]   = w_entry_err;

  // Largest distance first: register k handles shift bit SHW-1-k
  for (genvar k = 0; k < SHW; k++) begin : g_stage
    pbs_stage #(
      .WIDTH (WIDTH),
      .SHW   (SHW),
      .STAGE (SHW - 1 - k)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .advance   (w_advance),
      .in_valid  (p_valid[k]),
      .in_data   (p_data[k]),
      .in_shamt  (p_shamt[k]),
      .in_fill   (p_fill[k]),
      .in_rot    (p_rot[k]),
      .in_left   (p_left[k]),
      .in_err    (p_err[k]),
      .out_valid (p_valid[k+1]),
      .out_data  (p_data[k+1]),
      .out_shamt (p_shamt[k+1]),
      .out_fill  (p_fill[k+1]),
      .out_rot   (p_rot[k+1]),
      .out_left  (p_left[k+1]),
      .out_err   (p_err[k+1])
    );
  end

  // Shift amount, fill and rotate flag are spent once the last stage is done
  assign w_tail_unused = ^{p_shamt[SHW], p_fill[SHW], p_rot[SHW]};

  // Exit: undo the entry reversal for left ops
  assign out_valid = p_valid[SHW];
  assign out_err   = p_err[SHW];
  assign out_data  = p_left[SHW] ? WIDTH'(bitrev(MAX_W'(p_data[SHW]), WIDTH)) : p_data[SHW];

endmodule
`default_nettype wire

// File: doc/pipelined_barrel_shifter.md
Name: pipelined_barrel_shifter

Overview:
- Parametrised, pipelined barrel shifter with one registered mux stage per shift-amount bit.
- Supports logical, arithmetic, ones-fill and rotate shifts, both left and right.
- Adds a valid/ready handshake with whole-pipeline stall so it sits directly in a streaming datapath (ALU / DSP normaliser).
- Generalises the earlier fixed 32-bit, ones-fill, right-only combinational shifter.

Parameters:
WIDTH, 32, data width in bits; power of two, 8..64
SHW, $clog2(WIDTH), shift-amount width and number of pipeline stages (derived; do not override)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input beat valid
in_ready  output  1  shifter can accept a beat this cycle
in_data  input  WIDTH  operand
in_shamt  input  SHW  shift amount, 0..WIDTH-1
in_op  input  3  operation code (see Behaviour)
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_data  output  WIDTH  shifted result
out_err  output  1  beat carried reserved op code

Behaviour:
- One clock (clk) and one reset (rst_n). Reset is asynchronous and active-low.
- Op codes:
  - 000 SRL: right shift, zero fill.
  - 001 SRA: right shift, fill with in_data[WIDTH-1].
  - 010 SR1: right shift, ones fill.
  - 011 ROR: rotate right.
  - 100 SLL: left shift, zero fill.
  - 101 SL1: left shift, ones fill.
  - 110 ROL: rotate left.
  - 111 reserved.
- Left ops are implemented by bit-reversing the operand at entry and bit-reversing the result at exit, so only right-shift stages exist.
- Fill bit is computed once at entry and carried down the pipeline with the data. For SRA the fill is the original MSB.
- Stage i (i = SHW-1 down to 0) shifts by 2^i when shamt[i]=1. The stage-0 input is registered, so latency is SHW cycles from accept to out_valid (5 cycles for WIDTH=32).
- Each stage register holds: valid, data, remaining shamt bits, fill bit, op class (rotate/left), err.
- Handshake:
  - advance = !out_valid | out_ready.
  - in_ready = advance.
  - A beat is accepted when in_valid & in_ready.
  - All stage registers load only when advance=1; otherwise every stage holds.
  - Stall is global; internal bubbles are not collapsed.
  - A stage with valid=0 still loads on advance, so bubbles propagate.
- Throughput is 1 beat/cycle while out_ready=1.
- out_data and out_err are stable while out_valid=1 and out_ready=0.
- Reserved op 111: result = in_data unshifted, out_err=1 for that beat only. No other side effects.
- shamt=0: out_data = in_data for every op.
- Reset values: every stage valid=0, data=0, err=0. Hence out_valid=0, out_data=0, out_err=0. in_ready=1 once reset is released.
- Reset asserted mid-operation: all in-flight beats are discarded, no partial result is emitted.
- in_valid with in_ready=0: beat not taken; upstream must hold it.

Decomposition:
- Package pbs_pkg: op-code localparams (OP_SRL..OP_ROL, OP_RSV), and helper functions bitrev(WIDTH) and fill_bit(op, msb).
- Sub-module pbs_stage, instantiated SHW times via generate, parameterised by WIDTH and stage distance 2^i.
  - pbs_stage contains one 2:1 mux row and the stage register with the enable (advance).
  - Rotate selects wrapped bits instead of the fill bit.
- Top level holds entry reversal/fill logic, the exit reversal, and the handshake.

Test Plan:
- Reset, then WIDTH=32: SRL 0x80000001 shamt 4 → out_data=0x08000000 exactly 5 cycles after accept. SRA same operand → 0xF8000000.
- SR1 0x00000000 shamt 31 → 0xFFFFFFFE. ROR 0x0000000F shamt 4 → 0xF0000000. ROL 0x80000001 shamt 1 → 0x00000003. SL1 0x1 shamt 3 → 0x0000000F.
- Back-to-back stream of 32 beats with out_ready=1: one result per cycle, in order, each matching a software model (all ops, random shamt).
- out_ready held 0 for 10 cycles with pipeline full: in_ready=0, out_data stable; on release, 5 queued results drain in order with none lost or duplicated.
- op=111 data 0x12345678 shamt 7 → out_data=0x12345678, out_err=1. Next beat (SRL) → out_err=0.
- Assert rst_n low while 3 beats are in flight → out_valid=0 and out_data=0 immediately (asynchronous). After release, no stale results emerge. Repeat with WIDTH=8: SRA 0x90 shamt 3 → 0xF2 after 3 cycles.
